// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the two requester ports and the single memory port of the arbiter.
//   slave  : arbiter side (consumes requests and mem_q, drives grants/memory).
//   master : environment side (requesters plus the memory model).
//   Per requester N (0,1): rN_req, rN_wren, rN_lock, rN_addr, rN_wdata in;
//   rN_gnt, rN_rvalid, rN_rdata out.
//   Memory: mem_address, mem_data, mem_wren out; mem_q in.
interface mem_port_arbiter_if #(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18
);
  logic                 r0_req;
  logic                 r0_wren;
  logic                 r0_lock;
  logic [ADDR_SIZE-1:0] r0_addr;
  logic [WORD_SIZE-1:0] r0_wdata;
  logic                 r0_gnt;
  logic                 r0_rvalid;
  logic [WORD_SIZE-1:0] r0_rdata;

  logic                 r1_req;
  logic                 r1_wren;
  logic                 r1_lock;
  logic [ADDR_SIZE-1:0] r1_addr;
  logic [WORD_SIZE-1:0] r1_wdata;
  logic                 r1_gnt;
  logic                 r1_rvalid;
  logic [WORD_SIZE-1:0] r1_rdata;

  logic [ADDR_SIZE-1:0] mem_address;
  logic [WORD_SIZE-1:0] mem_data;
  logic                 mem_wren;
  logic [WORD_SIZE-1:0] mem_q;

  modport slave (
    input  r0_req, r0_wren, r0_lock, r0_addr, r0_wdata,
    input  r1_req, r1_wren, r1_lock, r1_addr, r1_wdata,
    input  mem_q,
    output r0_gnt, r0_rvalid, r0_rdata,
    output r1_gnt, r1_rvalid, r1_rdata,
    output mem_address, mem_data, mem_wren
  );

  modport master (
    output r0_req, r0_wren, r0_lock, r0_addr, r0_wdata,
    output r1_req, r1_wren, r1_lock, r1_addr, r1_wdata,
    output mem_q,
    input  r0_gnt, r0_rvalid, r0_rdata,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  mem_address, mem_data, mem_wren
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous memory port (1-cycle read latency) between two
//   requesters. Round-robin on contention, optional port locking with a
//   burst limit of MAX_BURST grants while the other side is waiting.
//   Ports: clock, reset (async, active-high), bus (mem_port_arbiter_if.slave).
//
//   state | meaning
//   IDLE  | no owner; grant single requester or prio on contention
//   OWN0  | r0 holds the port (locked); r1 stalls
//   OWN1  | r1 holds the port (locked); r0 stalls
module mem_port_arbiter #(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18,
  parameter int MAX_BURST = 8
) (
  input logic                clock,
  input logic                reset,
  mem_port_arbiter_if.slave  bus
);

  localparam int CNT_W = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             r0_rvalid_q, r1_rvalid_q;

  logic             gnt0, gnt1, both_req, lock_g, other_req;
  logic [ADDR_SIZE-1:0] addr_mux;
  logic [WORD_SIZE-1:0] data_mux;

  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    both_req = bus.r0_req & bus.r1_req;
    case (state_q)
      IDLE: begin
        if (both_req) begin
          gnt0 = ~prio_q;
          gnt1 = prio_q;
        end else begin
          gnt0 = bus.r0_req;
          gnt1 = bus.r1_req;
        end
      end
      OWN0:    gnt0 = bus.r0_req;
      OWN1:    gnt1 = bus.r1_req;
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    cnt_d     = cnt_q;
    lock_g    = gnt1 ? bus.r1_lock : bus.r0_lock;
    other_req = (state_q == OWN0) ? bus.r1_req : bus.r0_req;
    case (state_q)
      IDLE: begin
        if (gnt0 | gnt1) begin
          // prio only rotates when there was real contention
          if (both_req) prio_d = gnt0;
          if (lock_g) begin
            state_d = gnt1 ? OWN1 : OWN0;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      OWN0, OWN1: begin
        if (gnt0 | gnt1) begin
          if (!lock_g || (cnt_q == CNT_MAX && other_req)) begin
            state_d = IDLE;
            prio_d  = gnt0;
            cnt_d   = '0;
          end else if (cnt_q != CNT_MAX) begin
            // saturate: an uncontended owner may keep the port forever
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      cnt_q       <= '0;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      r0_rvalid_q <= gnt0 & ~bus.r0_wren;
      r1_rvalid_q <= gnt1 & ~bus.r1_wren;
    end
  end

  // without a grant the memory sees r0's fields with write disabled
  assign addr_mux = gnt1 ? bus.r1_addr  : bus.r0_addr;
  assign data_mux = gnt1 ? bus.r1_wdata : bus.r0_wdata;

  assign bus.mem_address = addr_mux;
  assign bus.mem_data    = data_mux;
  assign bus.mem_wren    = (gnt0 & bus.r0_wren) | (gnt1 & bus.r1_wren);

  assign bus.r0_gnt    = gnt0;
  assign bus.r1_gnt    = gnt1;
  assign bus.r0_rvalid = r0_rvalid_q;
  assign bus.r1_rvalid = r1_rvalid_q;
  assign bus.r0_rdata  = bus.mem_q;
  assign bus.r1_rdata  = bus.mem_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with a small synchronous memory model
//   and a traffic monitor for a randomised phase.
module tb_mem_port_arbiter;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_SIZE(18), .WORD_SIZE(18)) bus ();

  mem_port_arbiter #(.ADDR_SIZE(18), .WORD_SIZE(18), .MAX_BURST(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [17:0] mem [0:255];

  always @(posedge clock) begin
    if (bus.mem_wren) mem[bus.mem_address[7:0]] <= bus.mem_data;
    bus.mem_q <= mem[bus.mem_address[7:0]];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int n, input logic req, input logic wren, input logic lock,
                       input logic [17:0] addr, input logic [17:0] wdata);
    if (n == 0) begin
      bus.r0_req = req; bus.r0_wren = wren; bus.r0_lock = lock;
      bus.r0_addr = addr; bus.r0_wdata = wdata;
    end else begin
      bus.r1_req = req; bus.r1_wren = wren; bus.r1_lock = lock;
      bus.r1_addr = addr; bus.r1_wdata = wdata;
    end
  endtask

  // monitor for the random phase
  logic mon_en = 1'b0;
  logic g0_last = 1'b0, g1_last = 1'b0;
  int   n_two = 0, n_wr_nognt = 0, n_rd0 = 0, n_rd1 = 0, n_rv0 = 0, n_rv1 = 0;

  always @(negedge clock) begin
    g0_last <= bus.r0_gnt;
    g1_last <= bus.r1_gnt;
    if (mon_en) begin
      if (bus.r0_gnt & bus.r1_gnt) n_two <= n_two + 1;
      if (bus.mem_wren & ~(bus.r0_gnt | bus.r1_gnt)) n_wr_nognt <= n_wr_nognt + 1;
      if (bus.r0_gnt & ~bus.r0_wren) n_rd0 <= n_rd0 + 1;
      if (bus.r1_gnt & ~bus.r1_wren) n_rd1 <= n_rd1 + 1;
      if (bus.r0_rvalid) n_rv0 <= n_rv0 + 1;
      if (bus.r1_rvalid) n_rv1 <= n_rv1 + 1;
    end
  end

  int wait1, max_wait1;

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 18'h0, 18'h0);
    drive(1, 0, 0, 0, 18'h0, 18'h0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_gnt0",   32'(bus.r0_gnt),    0);
    check("rst_gnt1",   32'(bus.r1_gnt),    0);
    check("rst_rv0",    32'(bus.r0_rvalid), 0);
    check("rst_rv1",    32'(bus.r1_rvalid), 0);
    check("rst_wren",   32'(bus.mem_wren),  0);

    // r1 write alone, right on reset release
    step();
    reset = 1'b0;
    drive(1, 1, 1, 0, 18'h05, 18'h3FFFF);
    @(negedge clock);
    check("wr_gnt1",  32'(bus.r1_gnt),      1);
    check("wr_gnt0",  32'(bus.r0_gnt),      0);
    check("wr_wren",  32'(bus.mem_wren),    1);
    check("wr_addr",  32'(bus.mem_address), 32'h05);
    check("wr_data",  32'(bus.mem_data),    32'h3FFFF);
    step();
    drive(1, 0, 0, 0, 18'h0, 18'h0);
    drive(0, 1, 0, 0, 18'h05, 18'h0);
    @(negedge clock);
    check("rd_gnt0",  32'(bus.r0_gnt),      1);
    check("rd_wren",  32'(bus.mem_wren),    0);
    check("wr_norv1", 32'(bus.r1_rvalid),   0);
    step();
    drive(0, 0, 0, 0, 18'h0, 18'h0);
    @(negedge clock);
    check("rd_rv0",   32'(bus.r0_rvalid),   1);
    check("rd_data0", 32'(bus.r0_rdata),    32'h3FFFF);

    // preload 0x10 and 0x20
    step();
    drive(0, 1, 1, 0, 18'h10, 18'h00111);
    step();
    drive(0, 1, 1, 0, 18'h20, 18'h00222);
    step();
    drive(0, 0, 0, 0, 18'h0, 18'h0);

    // contention, both read, prio = 0
    step();
    drive(0, 1, 0, 0, 18'h10, 18'h0);
    drive(1, 1, 0, 0, 18'h20, 18'h0);
    @(negedge clock);
    check("cont_c1_gnt0", 32'(bus.r0_gnt), 1);
    check("cont_c1_gnt1", 32'(bus.r1_gnt), 0);
    check("cont_c1_addr", 32'(bus.mem_address), 32'h10);
    step();
    drive(0, 0, 0, 0, 18'h0, 18'h0);
    @(negedge clock);
    check("cont_c2_gnt1", 32'(bus.r1_gnt), 1);
    check("cont_c2_addr", 32'(bus.mem_address), 32'h20);
    check("cont_c2_rv0",  32'(bus.r0_rvalid), 1);
    check("cont_c2_rd0",  32'(bus.r0_rdata), 32'h111);
    step();
    drive(1, 0, 0, 0, 18'h0, 18'h0);
    @(negedge clock);
    check("cont_c3_rv1",  32'(bus.r1_rvalid), 1);
    check("cont_c3_rd1",  32'(bus.r1_rdata), 32'h222);
    check("cont_c3_rv0",  32'(bus.r0_rvalid), 0);

    // reset restores prio to r0
    step(); reset = 1'b1;
    step(); reset = 1'b0;

    // locked r0 burst against constant r1: 8 r0, 1 r1, repeat
    drive(0, 1, 0, 1, 18'h10, 18'h0);
    drive(1, 1, 0, 0, 18'h20, 18'h0);
    wait1 = 0; max_wait1 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check($sformatf("burst_gnt0_%0d", i), 32'(bus.r0_gnt), 32'((i % 9) != 8));
      check($sformatf("burst_gnt1_%0d", i), 32'(bus.r1_gnt), 32'((i % 9) == 8));
      if (i > 0) begin
        check($sformatf("burst_rv0_%0d", i), 32'(bus.r0_rvalid), 32'(((i - 1) % 9) != 8));
        check($sformatf("burst_rv1_%0d", i), 32'(bus.r1_rvalid), 32'(((i - 1) % 9) == 8));
      end
      if (bus.r1_gnt) wait1 = 0;
      else begin
        wait1++;
        if (wait1 > max_wait1) max_wait1 = wait1;
      end
      step();
    end
    check("burst_r1_wait_le8", 32'(max_wait1 <= 8), 1);

    // r1 idle: r0 keeps the port every cycle
    drive(1, 0, 0, 0, 18'h0, 18'h0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check($sformatf("own0_gnt0_%0d", i), 32'(bus.r0_gnt), 1);
      step();
    end
    // ownership kept while owner idles: r1 still stalls
    drive(0, 0, 0, 0, 18'h0, 18'h0);
    drive(1, 1, 0, 0, 18'h20, 18'h0);
    @(negedge clock);
    check("own0_hold_gnt1", 32'(bus.r1_gnt), 0);
    check("own0_hold_gnt0", 32'(bus.r0_gnt), 0);
    step();
    drive(0, 1, 0, 0, 18'h10, 18'h0);
    @(negedge clock);
    check("own0_rel_gnt0", 32'(bus.r0_gnt), 1);
    check("own0_rel_gnt1", 32'(bus.r1_gnt), 0);
    step();
    drive(0, 0, 0, 0, 18'h0, 18'h0);
    @(negedge clock);
    check("after_rel_gnt1", 32'(bus.r1_gnt), 1);

    // enter OWN1, reset with a read granted
    step();
    drive(1, 1, 0, 1, 18'h20, 18'h0);
    @(negedge clock);
    check("own1_enter_gnt1", 32'(bus.r1_gnt), 1);
    step();
    drive(0, 1, 0, 0, 18'h10, 18'h0);
    @(negedge clock);
    check("own1_gnt1",  32'(bus.r1_gnt), 1);
    check("own1_stall0", 32'(bus.r0_gnt), 0);
    #1 reset = 1'b1;
    step();
    check("rst_mid_rv1", 32'(bus.r1_rvalid), 0);
    reset = 1'b0;
    drive(1, 1, 0, 0, 18'h20, 18'h0);
    @(negedge clock);
    check("post_rst_gnt0", 32'(bus.r0_gnt), 1);
    check("post_rst_gnt1", 32'(bus.r1_gnt), 0);
    step();
    drive(0, 0, 0, 0, 18'h0, 18'h0);
    @(negedge clock);
    check("post_rst_next_gnt1", 32'(bus.r1_gnt), 1);

    // asynchronous clear of rvalid
    step();
    drive(1, 0, 0, 0, 18'h0, 18'h0);
    drive(0, 1, 0, 0, 18'h10, 18'h0);
    step();
    drive(0, 0, 0, 0, 18'h0, 18'h0);
    check("async_rv0_pre", 32'(bus.r0_rvalid), 1);
    #2 reset = 1'b1;
    #1;
    check("async_rv0_clr", 32'(bus.r0_rvalid), 0);
    step();
    reset = 1'b0;

    // random traffic with hold-until-grant requesters
    step();
    mon_en = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (!bus.r0_req || g0_last)
        drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              18'($urandom_range(0, 255)), 18'($urandom));
      if (!bus.r1_req || g1_last)
        drive(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              18'($urandom_range(0, 255)), 18'($urandom));
      step();
    end
    drive(0, 0, 0, 0, 18'h0, 18'h0);
    drive(1, 0, 0, 0, 18'h0, 18'h0);
    step();
    step();
    mon_en = 1'b0;
    step();
    check("rnd_two_gnt",    32'(n_two), 0);
    check("rnd_wren_nognt", 32'(n_wr_nognt), 0);
    check("rnd_rv0_count",  32'(n_rv0), 32'(n_rd0));
    check("rnd_rv1_count",  32'(n_rv1), 32'(n_rd1));
    check("rnd_traffic",    32'((n_rd0 > 0) && (n_rd1 > 0)), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_SIZE, default 18, width of all address buses.
REQ-002 Parameter WORD_SIZE, default 18, width of all data buses.
REQ-003 Parameter MAX_BURST, default 8, maximum consecutive grants held under lock while the other requester waits.
REQ-004 clock  in  1  single clock for all state; every register changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state immediately, independent of clock.
REQ-006 rN_req  in  1  (N=0,1) requester N has an access pending; held high until rN_gnt.
REQ-007 rN_wren  in  1  (N=0,1) pending access is a write (1) or read (0).
REQ-008 rN_lock  in  1  (N=0,1) keep port ownership after this access.
REQ-009 rN_addr  in  ADDR_SIZE  (N=0,1) access address.
REQ-010 rN_wdata  in  WORD_SIZE  (N=0,1) write data.
REQ-011 rN_gnt  out  1  (N=0,1) combinational; access presented to memory this cycle.
REQ-012 rN_rvalid  out  1  (N=0,1) registered; rN_rdata valid this cycle.
REQ-013 rN_rdata  out  WORD_SIZE  (N=0,1) driven from mem_q.
REQ-014 mem_address  out  ADDR_SIZE  to single memory port (synchronous, 1-cycle read latency).
REQ-015 mem_data  out  WORD_SIZE  write data to memory.
REQ-016 mem_wren  out  1  write enable to memory.
REQ-017 mem_q  in  WORD_SIZE  memory read data, valid one cycle after address.

Function
REQ-018 States: IDLE, OWN0, OWN1; plus 1-bit priority pointer prio and burst counter (width ceil(log2 MAX_BURST)).
REQ-019 At most one rN_gnt high per cycle; mem_wren = granted rN_wren, never high without a grant.
REQ-020 Granted requester's addr/wdata routed to mem_address/mem_data same cycle; no grant: mem from r0 fields, mem_wren=0.
REQ-021 IDLE: single requester granted immediately; both requesting: requester prio granted, then prio := other.
REQ-022 IDLE grant with lock=1 -> OWNn, counter := 1; lock=0 -> stay IDLE.
REQ-023 OWNn: only n grantable; other requester stalls; owner req low -> no grant, state held.
REQ-024 OWNn grant with lock=0 -> IDLE, prio := other, counter := 0.
REQ-025 OWNn grant while counter = MAX_BURST-1 and other req high -> forced IDLE, prio := other, regardless of lock.
REQ-026 OWNn with other req low: counter saturates at MAX_BURST-1, ownership unlimited.
REQ-027 Read grant in cycle t -> rN_rvalid high exactly cycle t+1 for that N only; write grants never raise rvalid.
REQ-028 Back-to-back read grants yield back-to-back rvalid pulses, one per grant, in grant order.
REQ-029 rN_rdata = mem_q continuously; content meaningful only with rN_rvalid.

Reset
REQ-030 On reset: state IDLE, prio=0 (r0 favoured), counter 0, r0_rvalid=r1_rvalid=0, mem_wren=0 while no req.
REQ-031 Reset mid-burst drops ownership; rvalid for a read granted in the reset cycle is suppressed.
REQ-032 First clock edge after reset release may grant; no extra idle cycle.

Verification
REQ-033 Both req read, r0_addr=0x10, r1_addr=0x20, lock=0 -> r0_gnt cycle 1, r1_gnt cycle 2, r0_rvalid cycle 2, r1_rvalid cycle 3 with mem contents.
REQ-034 r1 write 0x3FFFF to 0x05 alone -> r1_gnt, mem_wren=1, mem_address=0x05 same cycle; no rvalid; r0 read 0x05 next -> 0x3FFFF.
REQ-035 r0 lock=1 for 20 accesses, r1 req constantly, MAX_BURST=8 -> r0 gets 8 grants, r1 one, r0 resumes; r1 never waits >8 cycles.
REQ-036 r0 lock=1 burst, r1 idle -> r0 granted every cycle for 20 cycles, state stays OWN0.
REQ-037 Assert reset during OWN1 with read granted -> no rvalid next cycle, state IDLE, r0 wins next contention.
REQ-038 Random traffic checker: never two gnts, never mem_wren without gnt, rvalid count equals read grant count.
